// File: rtl/pattern_generator.sv
// rtl/pattern_generator.sv - six-mode animated video test-pattern source, 2-clock pipeline
//
// Sits between the video timing generator and the DVI encoder. DE/HS/VS are
// delayed by two clocks so they stay aligned with the pixel pipeline.
// Mode and colour are captured only at frame start, so a frame is never torn.
//
// Ports:
//   i_clk    pixel clock
//   i_rstn   asynchronous active-low reset
//   i_de     data enable from timing generator
//   i_hs     hsync from timing generator
//   i_vs     vsync from timing generator (polarity set by VS_ACTIVE_HIGH)
//   i_x      pixel column, valid when i_de=1
//   i_y      pixel row, valid when i_de=1
//   i_mode   requested pattern, sampled at frame start
//   i_color  user BGR colour, sampled at frame start
//   o_de     i_de delayed 2 clocks
//   o_hs     i_hs delayed 2 clocks
//   o_vs     i_vs delayed 2 clocks
//   o_bgr    pixel, [23:16]=B [15:8]=G [7:0]=R; zero during blanking
module pattern_generator #(
  parameter int H_ACTIVE       = 640,
  parameter int V_ACTIVE       = 480,
  parameter int XW             = 10,
  parameter int YW             = 10,
  parameter int VS_ACTIVE_HIGH = 0,
  parameter int BOX_SIZE       = 32,
  parameter int BOX_STEP       = 2,
  parameter int CHECK_SHIFT    = 5
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_de,
  input  logic          i_hs,
  input  logic          i_vs,
  input  logic [XW-1:0] i_x,
  input  logic [YW-1:0] i_y,
  input  logic [2:0]    i_mode,
  input  logic [23:0]   i_color,
  output logic          o_de,
  output logic          o_hs,
  output logic          o_vs,
  output logic [23:0]   o_bgr
);

  localparam int   BAR_W   = H_ACTIVE / 8;
  localparam logic VS_IDLE = (VS_ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;

  // ---------------------------------------------------------------------------
  // Frame start detection and per-frame state
  // ---------------------------------------------------------------------------
  logic          vs_prev;
  logic          fs;
  logic [2:0]    mode_q;
  logic [23:0]   color_q;
  logic [7:0]    frame_cnt;
  logic [XW-1:0] box_x, box_x_n;
  logic [YW-1:0] box_y, box_y_n;
  logic          dir_x_neg, dir_x_n;   // 0 = moving +, 1 = moving -
  logic          dir_y_neg, dir_y_n;

  assign fs = (i_vs != VS_IDLE) && (vs_prev == VS_IDLE);

  // Bounce logic: operands are widened by one bit so box+size+step cannot
  // wrap before being compared against the active width.
  always_comb begin
    box_x_n = box_x;
    dir_x_n = dir_x_neg;
    if (!dir_x_neg) begin
      if ({1'b0, box_x} + (XW+1)'(BOX_SIZE + BOX_STEP) > (XW+1)'(H_ACTIVE)) begin
        dir_x_n = 1'b1;
        box_x_n = box_x - XW'(BOX_STEP);
      end else begin
        box_x_n = box_x + XW'(BOX_STEP);
      end
    end else begin
      if (box_x < XW'(BOX_STEP)) begin
        dir_x_n = 1'b0;
        box_x_n = box_x + XW'(BOX_STEP);
      end else begin
        box_x_n = box_x - XW'(BOX_STEP);
      end
    end
  end

  always_comb begin
    box_y_n = box_y;
    dir_y_n = dir_y_neg;
    if (!dir_y_neg) begin
      if ({1'b0, box_y} + (YW+1)'(BOX_SIZE + BOX_STEP) > (YW+1)'(V_ACTIVE)) begin
        dir_y_n = 1'b1;
        box_y_n = box_y - YW'(BOX_STEP);
      end else begin
        box_y_n = box_y + YW'(BOX_STEP);
      end
    end else begin
      if (box_y < YW'(BOX_STEP)) begin
        dir_y_n = 1'b0;
        box_y_n = box_y + YW'(BOX_STEP);
      end else begin
        box_y_n = box_y - YW'(BOX_STEP);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      vs_prev   <= VS_IDLE;
      mode_q    <= '0;
      color_q   <= '0;
      frame_cnt <= '0;
      box_x     <= '0;
      box_y     <= '0;
      dir_x_neg <= 1'b0;
      dir_y_neg <= 1'b0;
    end else begin
      vs_prev <= i_vs;
      if (fs) begin
        mode_q    <= i_mode;
        color_q   <= i_color;
        frame_cnt <= frame_cnt + 8'd1;
        box_x     <= box_x_n;
        box_y     <= box_y_n;
        dir_x_neg <= dir_x_n;
        dir_y_neg <= dir_y_n;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: decode flags from the incoming coordinate. Mode, colour, frame
  // count and box position are captured here, so a pixel already in the pipe
  // when a frame start hits finishes with the settings it entered with.
  // ---------------------------------------------------------------------------
  logic       border_c, check_c, box_c;
  logic [2:0] bar_c;

  always_comb begin
    border_c = (i_x == '0) || (i_x == XW'(H_ACTIVE - 1)) ||
               (i_y == '0) || (i_y == YW'(V_ACTIVE - 1));
    check_c  = i_x[CHECK_SHIFT] ^ i_y[CHECK_SHIFT];
    box_c    = ({1'b0, i_x} >= {1'b0, box_x}) &&
               ({1'b0, i_x} <  {1'b0, box_x} + (XW+1)'(BOX_SIZE)) &&
               ({1'b0, i_y} >= {1'b0, box_y}) &&
               ({1'b0, i_y} <  {1'b0, box_y} + (YW+1)'(BOX_SIZE));
    // Bar index by threshold compare; columns past 8*BAR_W stay on bar 7.
    bar_c = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if ({1'b0, i_x} >= (XW+1)'(i * BAR_W)) bar_c = 3'(i);
    end
  end

  logic        s1_de, s1_hs, s1_vs;
  logic [7:0]  s1_x8, s1_y8, s1_fcnt;
  logic [2:0]  s1_mode, s1_bar;
  logic [23:0] s1_color;
  logic        s1_border, s1_check, s1_box;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      s1_de     <= 1'b0;
      s1_hs     <= 1'b0;
      s1_vs     <= 1'b0;
      s1_x8     <= '0;
      s1_y8     <= '0;
      s1_fcnt   <= '0;
      s1_mode   <= '0;
      s1_bar    <= '0;
      s1_color  <= '0;
      s1_border <= 1'b0;
      s1_check  <= 1'b0;
      s1_box    <= 1'b0;
    end else begin
      s1_de     <= i_de;
      s1_hs     <= i_hs;
      s1_vs     <= i_vs;
      s1_x8     <= i_x[7:0];
      s1_y8     <= i_y[7:0];
      s1_fcnt   <= frame_cnt;
      s1_mode   <= mode_q;
      s1_bar    <= bar_c;
      s1_color  <= color_q;
      s1_border <= border_c;
      s1_check  <= check_c;
      s1_box    <= box_c;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: pixel mux
  // ---------------------------------------------------------------------------
  logic [23:0] pix;

  always_comb begin
    pix = 24'h000000;
    case (s1_mode)
      3'd0: pix = s1_border ? 24'hFFFFFF : 24'h000000;
      3'd1: pix = s1_color;
      3'd2: begin
        case (s1_bar)
          3'd0:    pix = 24'hFFFFFF;
          3'd1:    pix = 24'h00FFFF;
          3'd2:    pix = 24'hFFFF00;
          3'd3:    pix = 24'h00FF00;
          3'd4:    pix = 24'hFF00FF;
          3'd5:    pix = 24'h0000FF;
          3'd6:    pix = 24'hFF0000;
          default: pix = 24'h000000;
        endcase
      end
      3'd3: pix = s1_check ? 24'hFFFFFF : 24'h000000;
      3'd4: pix = {s1_fcnt, s1_y8, s1_x8};
      3'd5: pix = s1_box ? s1_color : 24'h000000;
      default: pix = 24'h000000;
    endcase
    if (!s1_de) pix = 24'h000000;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_de  <= 1'b0;
      o_hs  <= 1'b0;
      o_vs  <= 1'b0;
      o_bgr <= '0;
    end else begin
      o_de  <= s1_de;
      o_hs  <= s1_hs;
      o_vs  <= s1_vs;
      o_bgr <= pix;
    end
  end

endmodule

// File: tb/tb_pattern_generator.sv
// tb/tb_pattern_generator.sv - directed self-checking bench for pattern_generator
module tb_pattern_generator;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic        i_de = 1'b0;
  logic        i_hs = 1'b0;
  logic        i_vs = 1'b1;   // vsync is active low, idle high
  logic [9:0]  i_x = '0;
  logic [9:0]  i_y = '0;
  logic [2:0]  i_mode = '0;
  logic [23:0] i_color = '0;
  logic        o_de, o_hs, o_vs;
  logic [23:0] o_bgr;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] fcnt = '0;   // frame starts issued since the last reset

  pattern_generator dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_de(i_de), .i_hs(i_hs), .i_vs(i_vs),
    .i_x(i_x), .i_y(i_y), .i_mode(i_mode), .i_color(i_color),
    .o_de(o_de), .o_hs(o_hs), .o_vs(o_vs), .o_bgr(o_bgr)
  );

  always #5 i_clk = ~i_clk;

  // Drives one active pixel (called at a negedge) and returns what emerges 2 clocks later.
  task automatic px(input int x, input int y, output logic [23:0] bgr, output logic de);
    i_de = 1'b1;
    i_x  = x[9:0];
    i_y  = y[9:0];
    @(negedge i_clk);
    i_de = 1'b0;
    @(negedge i_clk);
    bgr = o_bgr;
    de  = o_de;
  endtask

  task automatic frame_start();
    i_vs = 1'b0;
    @(negedge i_clk);
    i_vs = 1'b1;
    @(negedge i_clk);
    fcnt = fcnt + 8'd1;
  endtask

  task automatic test_reset();
    logic [23:0] b;
    logic        d;
    repeat (3) @(negedge i_clk);
    n_cmp++;
    if ({o_de, o_hs, o_vs, o_bgr} !== 27'd0) begin
      n_bad++;
      $display("FAIL reset_state: got de=%b hs=%b vs=%b bgr=%h expected all 0", o_de, o_hs, o_vs, o_bgr);
    end
    i_rstn = 1'b1;
    fcnt = '0;
    @(negedge i_clk);
    i_mode = 3'd1;
    i_color = 24'h0000FF;
    frame_start();
    // Mid-line: hold an active pixel with hs high so every output is non-zero.
    i_de = 1'b1; i_hs = 1'b1; i_x = 10'd0; i_y = 10'd5;
    repeat (2) @(negedge i_clk);
    n_cmp++;
    if ({o_de, o_hs, o_vs, o_bgr} !== {3'b111, 24'h0000FF}) begin
      n_bad++;
      $display("FAIL pre_reset_active: got de=%b hs=%b vs=%b bgr=%h expected 1 1 1 0000ff", o_de, o_hs, o_vs, o_bgr);
    end
    #2 i_rstn = 1'b0;
    #1;
    n_cmp++;
    if ({o_de, o_hs, o_vs, o_bgr} !== 27'd0) begin
      n_bad++;
      $display("FAIL reset_midline: got de=%b hs=%b vs=%b bgr=%h expected all 0", o_de, o_hs, o_vs, o_bgr);
    end
    @(negedge i_clk);
    i_rstn = 1'b1; i_de = 1'b0; i_hs = 1'b0;
    fcnt = '0;
    @(negedge i_clk);
    // i_mode is still 1, but no frame start yet: border mode must be in force.
    px(320, 240, b, d);
    n_cmp++;
    if (b !== 24'h000000) begin
      n_bad++;
      $display("FAIL post_reset_interior: got %h expected 000000", b);
    end
    px(0, 5, b, d);
    n_cmp++;
    if (b !== 24'hFFFFFF) begin
      n_bad++;
      $display("FAIL post_reset_border: got %h expected ffffff", b);
    end
    i_mode = 3'd0;
  endtask

  task automatic test_latency();
    logic [26:0] exp_seq [3];
    exp_seq[0] = {3'b000, 24'h000000};
    exp_seq[1] = {3'b110, 24'hFFFFFF};   // {o_hs, o_de, o_vs-ignored, bgr}
    exp_seq[2] = {3'b000, 24'h000000};
    i_hs = 1'b1; i_de = 1'b1; i_x = 10'd0; i_y = 10'd100;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      i_hs = 1'b0; i_de = 1'b0;
      n_cmp++;
      if ({o_hs, o_de, o_bgr} !== {exp_seq[k][26:25], exp_seq[k][23:0]}) begin
        n_bad++;
        $display("FAIL latency_hs_de_%0d: got hs=%b de=%b bgr=%h expected hs=%b de=%b bgr=%h",
                 k, o_hs, o_de, o_bgr, exp_seq[k][26], exp_seq[k][25], exp_seq[k][23:0]);
      end
    end
    i_vs = 1'b0;
    @(negedge i_clk);
    i_vs = 1'b1;
    fcnt = fcnt + 8'd1;
    n_cmp++;
    if (o_vs !== 1'b1) begin n_bad++; $display("FAIL latency_vs_n1: got %b expected 1", o_vs); end
    @(negedge i_clk);
    n_cmp++;
    if (o_vs !== 1'b0) begin n_bad++; $display("FAIL latency_vs_n2: got %b expected 0", o_vs); end
    @(negedge i_clk);
    n_cmp++;
    if (o_vs !== 1'b1) begin n_bad++; $display("FAIL latency_vs_n3: got %b expected 1", o_vs); end
  endtask

  task automatic test_border();
    int          xs [5] = '{0, 639, 320, 320, 320};
    int          ys [5] = '{5, 200, 479, 240, 0};
    logic [23:0] ex [5] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'h000000, 24'hFFFFFF};
    logic [23:0] b;
    logic        d;
    for (int k = 0; k < 5; k++) begin
      px(xs[k], ys[k], b, d);
      n_cmp++;
      if (b !== ex[k] || d !== 1'b1) begin
        n_bad++;
        $display("FAIL border_%0d_%0d: got bgr=%h de=%b expected %h de=1", xs[k], ys[k], b, d, ex[k]);
      end
    end
  endtask

  task automatic test_mode_latch();
    logic [23:0] b;
    logic        d;
    i_mode = 3'd1;
    i_color = 24'h123456;
    px(320, 240, b, d);
    n_cmp++;
    if (b !== 24'h000000) begin n_bad++; $display("FAIL latch_midframe: got %h expected 000000", b); end
    frame_start();
    px(320, 240, b, d);
    n_cmp++;
    if (b !== 24'h123456) begin n_bad++; $display("FAIL latch_solid_interior: got %h expected 123456", b); end
    i_color = 24'hABCDEF;   // not latched until the next frame start
    px(0, 0, b, d);
    n_cmp++;
    if (b !== 24'h123456) begin n_bad++; $display("FAIL latch_solid_corner: got %h expected 123456", b); end
    // Frame start coincident with an active pixel: that pixel keeps the old mode.
    i_mode = 3'd0;
    i_vs = 1'b0; i_de = 1'b1; i_x = 10'd320; i_y = 10'd240;
    @(negedge i_clk);
    @(negedge i_clk);
    i_vs = 1'b1; i_de = 1'b0;
    fcnt = fcnt + 8'd1;
    n_cmp++;
    if (o_bgr !== 24'h123456) begin n_bad++; $display("FAIL inflight_old_mode: got %h expected 123456", o_bgr); end
    @(negedge i_clk);
    n_cmp++;
    if (o_bgr !== 24'h000000) begin n_bad++; $display("FAIL inflight_new_mode: got %h expected 000000", o_bgr); end
  endtask

  task automatic test_bars_checker();
    int          bx [6] = '{0, 79, 80, 160, 560, 639};
    logic [23:0] be [6] = '{24'hFFFFFF, 24'hFFFFFF, 24'h00FFFF, 24'hFFFF00, 24'h000000, 24'h000000};
    int          cx [4] = '{32, 32, 0, 63};
    int          cy [4] = '{0, 32, 0, 64};
    logic [23:0] ce [4] = '{24'hFFFFFF, 24'h000000, 24'h000000, 24'hFFFFFF};
    logic [23:0] b;
    logic        d;
    i_mode = 3'd2;
    frame_start();
    for (int k = 0; k < 6; k++) begin
      px(bx[k], 100, b, d);
      n_cmp++;
      if (b !== be[k]) begin n_bad++; $display("FAIL bars_x%0d: got %h expected %h", bx[k], b, be[k]); end
    end
    i_mode = 3'd3;
    frame_start();
    for (int k = 0; k < 4; k++) begin
      px(cx[k], cy[k], b, d);
      n_cmp++;
      if (b !== ce[k]) begin n_bad++; $display("FAIL checker_%0d_%0d: got %h expected %h", cx[k], cy[k], b, ce[k]); end
    end
  endtask

  task automatic test_gradient_reserved();
    logic [23:0] b;
    logic        d;
    i_mode = 3'd4;
    frame_start();
    px(300, 200, b, d);
    n_cmp++;
    if (b !== {fcnt, 8'hC8, 8'h2C}) begin n_bad++; $display("FAIL gradient: got %h expected %h", b, {fcnt, 8'hC8, 8'h2C}); end
    i_mode = 3'd6;
    frame_start();
    px(0, 0, b, d);
    n_cmp++;
    if (b !== 24'h000000) begin n_bad++; $display("FAIL reserved6: got %h expected 000000", b); end
    i_mode = 3'd7;
    frame_start();
    px(639, 479, b, d);
    n_cmp++;
    if (b !== 24'h000000) begin n_bad++; $display("FAIL reserved7: got %h expected 000000", b); end
  endtask

  task automatic test_box();
    logic [23:0] b;
    logic        d;
    int          p, bx, by;
    int          max_x, max_y;
    max_x = 0; max_y = 0;
    i_rstn = 1'b0;
    @(negedge i_clk);
    i_rstn = 1'b1;
    fcnt = '0;
    @(negedge i_clk);
    i_color = 24'h00AA55;
    for (int n = 1; n <= 400; n++) begin
      i_mode = (n == 255 || n == 256) ? 3'd4 : 3'd5;
      frame_start();
      // Triangle-wave position: x period 1216/2 frames, y period 896/2 frames.
      p  = (2 * n) % 1216;
      bx = (p <= 608) ? p : 1216 - p;
      p  = (2 * n) % 896;
      by = (p <= 448) ? p : 896 - p;
      if (bx > max_x) max_x = bx;
      if (by > max_y) max_y = by;
      if (n == 255 || n == 256) begin
        px(0, 0, b, d);
        n_cmp++;
        if (b !== {n[7:0], 16'h0000}) begin
          n_bad++;
          $display("FAIL frame_cnt_wrap_%0d: got %h expected %h", n, b, {n[7:0], 16'h0000});
        end
      end else begin
        px(bx, by, b, d);
        n_cmp++;
        if (b !== 24'h00AA55) begin n_bad++; $display("FAIL box_tl_f%0d: got %h expected 00aa55 at (%0d,%0d)", n, b, bx, by); end
        px(bx + 31, by + 31, b, d);
        n_cmp++;
        if (b !== 24'h00AA55) begin n_bad++; $display("FAIL box_br_f%0d: got %h expected 00aa55", n, b); end
        px(bx + 32, by, b, d);
        n_cmp++;
        if (b !== 24'h000000) begin n_bad++; $display("FAIL box_right_f%0d: got %h expected 000000", n, b); end
        px(bx, by + 32, b, d);
        n_cmp++;
        if (b !== 24'h000000) begin n_bad++; $display("FAIL box_below_f%0d: got %h expected 000000", n, b); end
        if (bx > 0) begin
          px(bx - 1, by, b, d);
          n_cmp++;
          if (b !== 24'h000000) begin n_bad++; $display("FAIL box_left_f%0d: got %h expected 000000", n, b); end
        end
        if (by > 0) begin
          px(bx, by - 1, b, d);
          n_cmp++;
          if (b !== 24'h000000) begin n_bad++; $display("FAIL box_above_f%0d: got %h expected 000000", n, b); end
        end
      end
    end
    if (max_x != 608 || max_y != 448) $display("note: box model extremes %0d,%0d", max_x, max_y);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_border();
    test_mode_latch();
    test_bars_checker();
    test_gradient_reserved();
    test_box();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
